cop_req_ctrl: RTL and testbench
===============================

// Module: cop_req_ctrl
// PURPOSE
//  Initiator side of the coprocessor-0 op interface. Collects trap/return/IE requests from the
//  execute stage and async interrupt lines. Prioritises them and issues one cop_op per event.
//  Captures the vector/EPC returned on cop_out. Stalls, flushes and redirects the fetch PC.
// PARAMETERS
//  NIRQ     6             number of external interrupt lines
//  INT_VEC  32'h0000_3000 redirect target for interrupts (CP0 returns no vector for INT)
// PORTS
//  clk          in   1   single clock, rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  ex_valid     in   1   execute stage holds a valid instruction
//  ex_syscall   in   1   syscall in EX
//  ex_break     in   1   break in EX
//  ex_eret      in   1   eret in EX
//  ex_ei        in   1   ei in EX
//  ex_di        in   1   di in EX
//  ex_code      in   20  syscall/break code field
//  ex_pc_next   in   32  PC of the instruction following EX
//  irq          in   NIRQ  async interrupt lines, active-high level
//  cop_op       out  3   op to CP0; COP_OP_NOP when idle
//  cop_code     out  20  code to CP0, registered with cop_op
//  cop_next_pc  out  32  EPC candidate to CP0, registered with cop_op
//  cop_out      in   32  CP0 result (vector or EPC); valid during the ISSUE cycle
//  stall        out  1   freeze IF/ID/EX
//  flush        out  1   one-cycle kill of IF/ID/EX contents
//  redir_valid  out  1   one-cycle PC load strobe
//  redir_pc     out  32  PC load value
//  in_handler   out  1   trap/interrupt taken, eret not yet executed
//  irq_pend     out  NIRQ  latched pending interrupts (debug/status)
// BEHAVIOUR
//  Reset: all outputs 0 (cop_op = COP_OP_NOP). state=IDLE, ie=0, in_handler=0, sync FFs and pending cleared.
//  irq path
//   - Two-FF synchroniser per line.
//   - A rising edge of the synced line sets irq_pend[i].
//   - irq_pend[i] is cleared only when INT is issued for the lowest set index i.
//  Local ie shadow: EN sets it, DIS clears it. int_ok = ie & ~in_handler & |irq_pend.
//  Request select in IDLE, fixed priority:
//    ex_break > ex_syscall > ex_eret > ex_di > ex_ei > int_ok
//   - ex_* flags count only when ex_valid=1.
//   - Multiple ex_* flags: the highest wins; the others are dropped. The instruction is flushed or completes.
//  FSM: IDLE -> ISSUE -> CAPTURE -> REDIR -> IDLE
//   - IDLE, request accepted at cycle t:
//     - latch op, ex_code and ex_pc_next; go to ISSUE.
//     - stall=1 combinationally in cycle t.
//   - ISSUE (t+1):
//     - cop_op/cop_code/cop_next_pc driven from registers.
//     - cop_out sampled into redir_pc at the end of the cycle.
//     - For INT, redir_pc <= INT_VEC instead of cop_out.
//     - EN/DIS: update ie, go straight to IDLE; no flush, no redirect.
//   - CAPTURE (t+2): cop_op=NOP, stall=1.
//   - REDIR (t+3): redir_valid=1, flush=1, stall=0; then IDLE.
//  Total trap latency: 3 cycles from acceptance to PC load.
//  in_handler:
//   - set in ISSUE for SYS/BRK/INT; cleared in ISSUE for RET.
//   - Set and clear in the same cycle cannot occur (one op per pass).
//  Other ISSUE side effects:
//   - INT clears ie.
//   - RET does not change ie.
//  stall = (state!=IDLE && state!=REDIR) | accept.
//  Boundary cases:
//   - irq edge while busy stays pending and is taken on the next IDLE evaluation.
//   - ex_* requests while busy are ignored; EX is frozen by stall and re-presents them.
//   - Back-to-back: a request present in the cycle after REDIR is accepted normally.
//   - rst_n low mid-operation aborts asynchronously to the reset state. No flush/redirect is emitted.
// STRUCTURE
//  Shared package common.v holds:
//   - COP_OP_NOP=0, MV=1, EN=2, DIS=3, RET=4, SYS=5, BRK=6, INT=7 (new).
//   - The state encoding localparams IDLE/ISSUE/CAPTURE/REDIR.
//  One sub-module: irq_sync_edge, parameterised on NIRQ. It holds the two-FF synchroniser, the rising-edge detect and the pend set/clear.
// TESTING
//  1 syscall, ex_code=20'h12, ex_pc_next=32'h40, cop_out=32'h3000
//    -> t+1: cop_op=SYS, cop_next_pc=32'h40
//    -> t+3: redir_valid=1, redir_pc=32'h3000, flush=1; in_handler=1
//  2 eret while in_handler, cop_out=32'h44
//    -> t+1: cop_op=RET
//    -> t+3: redir_pc=32'h44; in_handler=0
//  3 ei, then irq[2] pulsed 4 cycles
//    -> pend[2]=1 three cycles after the edge; then INT issued
//    -> redir_pc=INT_VEC; pend[2]=0; ie=0
//  4 irq[1] and irq[3] rise together with ie=1 -> INT for line 1 first; line 3 waits until eret and ei
//  5 ex_break=ex_syscall=1 same cycle -> only BRK issued; one redirect; stall high for exactly t..t+2
//  6 rst_n low during CAPTURE
//    -> next edge: all outputs 0; no redir_valid
//    -> after release, a syscall completes in 3 cycles

Source files
------------

// File: rtl/cop_req_ctrl_pkg.sv
// Shared types for the CP0 request controller: op codes, FSM states, latched request.
package cop_req_ctrl_pkg;

  typedef enum logic [2:0] {
    COP_OP_NOP = 3'd0,
    COP_OP_MV  = 3'd1,
    COP_OP_EN  = 3'd2,
    COP_OP_DIS = 3'd3,
    COP_OP_RET = 3'd4,
    COP_OP_SYS = 3'd5,
    COP_OP_BRK = 3'd6,
    COP_OP_INT = 3'd7
  } cop_op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    REDIR   = 2'd3
  } state_e;

  localparam logic [31:0] INT_VEC_DFLT = 32'h0000_3000;

  typedef struct packed {
    cop_op_e     op;
    logic [19:0] code;
    logic [31:0] pc;
  } cop_req_t;

  // Fixed-priority request select; NOP means nothing to issue.
  function automatic cop_op_e sel_op(input logic brk, input logic sys, input logic eret,
                                     input logic di, input logic ei, input logic int_ok);
    cop_op_e op;
    op = COP_OP_NOP;
    if (brk)         op = COP_OP_BRK;
    else if (sys)    op = COP_OP_SYS;
    else if (eret)   op = COP_OP_RET;
    else if (di)     op = COP_OP_DIS;
    else if (ei)     op = COP_OP_EN;
    else if (int_ok) op = COP_OP_INT;
    return op;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Purpose: two-FF synchroniser, rising-edge detect and sticky pending per irq line.
// Latency: edge on irq to pending bit set is three clocks.
// Backpressure: none; pending bits hold until cleared by clr.
module irq_sync_edge #(
  parameter int NIRQ = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NIRQ-1:0] irq,
  input  logic [NIRQ-1:0] clr,
  output logic [NIRQ-1:0] pend
);

  logic [NIRQ-1:0] sync1;
  logic [NIRQ-1:0] sync2;
  logic [NIRQ-1:0] sync3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
      pend  <= '0;
    end else begin
      sync1 <= irq;
      sync2 <= sync1;
      sync3 <= sync2;
      // A fresh edge wins over a simultaneous clear so it is never lost.
      pend  <= (pend & ~clr) | (sync2 & ~sync3);
    end
  end

endmodule

// File: rtl/cop_req_ctrl.sv
// Purpose: prioritise EX trap/return/IE requests and irqs, issue one CP0 op each, redirect fetch.
// Latency: accept at t, op on cop_op at t+1, PC redirect + flush at t+3 (EN/DIS finish at t+1).
// Backpressure: stall freezes IF/ID/EX from acceptance until the redirect cycle.
module cop_req_ctrl
  import cop_req_ctrl_pkg::*;
#(
  parameter int          NIRQ    = 6,
  parameter logic [31:0] INT_VEC = INT_VEC_DFLT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic            ex_syscall,
  input  logic            ex_break,
  input  logic            ex_eret,
  input  logic            ex_ei,
  input  logic            ex_di,
  input  logic [19:0]     ex_code,
  input  logic [31:0]     ex_pc_next,
  input  logic [NIRQ-1:0] irq,
  output logic [2:0]      cop_op,
  output logic [19:0]     cop_code,
  output logic [31:0]     cop_next_pc,
  input  logic [31:0]     cop_out,
  output logic            stall,
  output logic            flush,
  output logic            redir_valid,
  output logic [31:0]     redir_pc,
  output logic            in_handler,
  output logic [NIRQ-1:0] irq_pend
);

  state_e          state;
  cop_req_t        req_q;
  cop_op_e         cop_op_q;
  cop_op_e         req_op;
  logic            ie;
  logic            ex_hold;
  logic            ex_ok;
  logic            int_ok;
  logic            accept;
  logic [NIRQ-1:0] int_sel;
  logic [NIRQ-1:0] pend_clr;

  irq_sync_edge #(.NIRQ(NIRQ)) u_irq (
    .clk   (clk),
    .rst_n (rst_n),
    .irq   (irq),
    .clr   (pend_clr),
    .pend  (irq_pend)
  );

  // EN/DIS complete without a flush; mask EX for the one cycle in which it retires.
  assign ex_ok    = ex_valid & ~ex_hold;
  assign int_ok   = ie & ~in_handler & (|irq_pend);
  assign req_op   = sel_op(ex_ok & ex_break, ex_ok & ex_syscall, ex_ok & ex_eret,
                           ex_ok & ex_di, ex_ok & ex_ei, int_ok);
  assign accept   = (state == IDLE) && (req_op != COP_OP_NOP);
  assign stall    = (state == ISSUE) || (state == CAPTURE) || accept;
  assign pend_clr = ((state == ISSUE) && (req_q.op == COP_OP_INT)) ? int_sel : '0;

  assign cop_op      = cop_op_q;
  assign cop_code    = req_q.code;
  assign cop_next_pc = req_q.pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_q       <= '0;
      cop_op_q    <= COP_OP_NOP;
      ie          <= 1'b0;
      in_handler  <= 1'b0;
      ex_hold     <= 1'b0;
      int_sel     <= '0;
      redir_valid <= 1'b0;
      flush       <= 1'b0;
      redir_pc    <= '0;
    end else begin
      redir_valid <= 1'b0;
      flush       <= 1'b0;
      ex_hold     <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            req_q.op   <= req_op;
            req_q.code <= ex_code;
            req_q.pc   <= ex_pc_next;
            cop_op_q   <= req_op;
            // Lowest set pending line is the one this INT services.
            int_sel    <= irq_pend & (~irq_pend + NIRQ'(1));
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          cop_op_q <= COP_OP_NOP;
          state    <= CAPTURE;
          case (req_q.op)
            COP_OP_EN: begin
              ie      <= 1'b1;
              ex_hold <= 1'b1;
              state   <= IDLE;
            end
            COP_OP_DIS: begin
              ie      <= 1'b0;
              ex_hold <= 1'b1;
              state   <= IDLE;
            end
            COP_OP_RET: begin
              in_handler <= 1'b0;
              redir_pc   <= cop_out;
            end
            COP_OP_INT: begin
              in_handler <= 1'b1;
              ie         <= 1'b0;
              redir_pc   <= INT_VEC;
            end
            COP_OP_SYS, COP_OP_BRK: begin
              in_handler <= 1'b1;
              redir_pc   <= cop_out;
            end
            default: state <= IDLE;
          endcase
        end
        CAPTURE: begin
          redir_valid <= 1'b1;
          flush       <= 1'b1;
          state       <= REDIR;
        end
        REDIR:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cop_req_ctrl.sv
// Directed bench for cop_req_ctrl: drives just after posedge, checks on negedge.
`timescale 1ns/1ps
module tb_cop_req_ctrl;
  import cop_req_ctrl_pkg::*;

  localparam int          NIRQ    = 6;
  localparam logic [31:0] INT_VEC = 32'h0000_3000;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ex_valid, ex_syscall, ex_break, ex_eret, ex_ei, ex_di;
  logic [19:0]     ex_code;
  logic [31:0]     ex_pc_next;
  logic [NIRQ-1:0] irq;
  logic [2:0]      cop_op;
  logic [19:0]     cop_code;
  logic [31:0]     cop_next_pc;
  logic [31:0]     cop_out;
  logic            stall, flush, redir_valid, in_handler;
  logic [31:0]     redir_pc;
  logic [NIRQ-1:0] irq_pend;

  int tests = 0;
  int fails = 0;

  cop_req_ctrl #(.NIRQ(NIRQ), .INT_VEC(INT_VEC)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_syscall(ex_syscall),
    .ex_break(ex_break), .ex_eret(ex_eret), .ex_ei(ex_ei), .ex_di(ex_di),
    .ex_code(ex_code), .ex_pc_next(ex_pc_next), .irq(irq), .cop_op(cop_op),
    .cop_code(cop_code), .cop_next_pc(cop_next_pc), .cop_out(cop_out),
    .stall(stall), .flush(flush), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .in_handler(in_handler), .irq_pend(irq_pend)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_ex();
    ex_valid = 0; ex_syscall = 0; ex_break = 0; ex_eret = 0; ex_ei = 0; ex_di = 0;
  endtask

  // Stimulus only: one EX-originated op, returning at the negedge of its last busy cycle.
  task automatic run_op(input cop_op_e kind, input logic [31:0] pc, input logic [31:0] cout);
    next_cyc();
    ex_valid   = 1;
    ex_break   = (kind == COP_OP_BRK);
    ex_syscall = (kind == COP_OP_SYS);
    ex_eret    = (kind == COP_OP_RET);
    ex_di      = (kind == COP_OP_DIS);
    ex_ei      = (kind == COP_OP_EN);
    ex_pc_next = pc;
    mid();
    next_cyc(); clear_ex(); cop_out = cout; mid();
    if (kind != COP_OP_EN && kind != COP_OP_DIS) begin
      next_cyc(); cop_out = '0; mid();
      next_cyc(); mid();
    end else begin
      cop_out = '0;
    end
  endtask

  task automatic test_reset();
    rst_n = 0; clear_ex(); ex_code = '0; ex_pc_next = '0; irq = '0; cop_out = '0;
    repeat (3) @(posedge clk);
    mid();
    tests++;
    if ({cop_op, cop_code, cop_next_pc, stall, flush, redir_valid, redir_pc, in_handler, irq_pend} !== '0)
      begin fails++; $display("FAIL reset_outputs: got op=%0d stall=%0b pend=%b rv=%0b, want all 0", cop_op, stall, irq_pend, redir_valid); end
    next_cyc(); rst_n = 1; mid();
  endtask

  task automatic test_syscall();
    next_cyc(); ex_valid = 1; ex_syscall = 1; ex_code = 20'h12; ex_pc_next = 32'h40; mid();
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL sys_t_stall: got %0b want 1", stall); end
    next_cyc(); cop_out = 32'h3000; mid();
    tests++; if (cop_op !== COP_OP_SYS) begin fails++; $display("FAIL sys_t1_op: got %0d want %0d", cop_op, COP_OP_SYS); end
    tests++; if (cop_next_pc !== 32'h40) begin fails++; $display("FAIL sys_t1_pc: got %h want 00000040", cop_next_pc); end
    tests++; if (cop_code !== 20'h12) begin fails++; $display("FAIL sys_t1_code: got %h want 00012", cop_code); end
    next_cyc(); cop_out = '0; mid();
    tests++; if ({cop_op, stall, redir_valid} !== {COP_OP_NOP, 1'b1, 1'b0}) begin fails++; $display("FAIL sys_t2: got op=%0d stall=%0b rv=%0b want 0/1/0", cop_op, stall, redir_valid); end
    next_cyc(); clear_ex(); mid();
    tests++; if ({redir_valid, flush, stall} !== 3'b110) begin fails++; $display("FAIL sys_t3_strobes: got rv/flush/stall=%b want 110", {redir_valid, flush, stall}); end
    tests++; if (redir_pc !== 32'h3000) begin fails++; $display("FAIL sys_t3_redir_pc: got %h want 00003000", redir_pc); end
    tests++; if (in_handler !== 1'b1) begin fails++; $display("FAIL sys_in_handler: got %0b want 1", in_handler); end
    next_cyc(); mid();
    tests++; if ({redir_valid, flush} !== 2'b00) begin fails++; $display("FAIL sys_t4_strobes: got %b want 00", {redir_valid, flush}); end
  endtask

  task automatic test_eret();
    next_cyc(); ex_valid = 1; ex_eret = 1; ex_pc_next = 32'h80; mid();
    next_cyc(); clear_ex(); cop_out = 32'h44; mid();
    tests++; if (cop_op !== COP_OP_RET) begin fails++; $display("FAIL ret_t1_op: got %0d want %0d", cop_op, COP_OP_RET); end
    next_cyc(); cop_out = '0; mid();
    next_cyc(); mid();
    tests++; if ({redir_valid, redir_pc} !== {1'b1, 32'h44}) begin fails++; $display("FAIL ret_t3_redir: got rv=%0b pc=%h want 1/00000044", redir_valid, redir_pc); end
    tests++; if (in_handler !== 1'b0) begin fails++; $display("FAIL ret_in_handler: got %0b want 0", in_handler); end
  endtask

  task automatic test_irq_single();
    run_op(COP_OP_EN, 32'h100, 32'h0);
    next_cyc(); mid();
    tests++; if ({stall, cop_op} !== {1'b0, COP_OP_NOP}) begin fails++; $display("FAIL ei_done: got stall=%0b op=%0d want 0/0", stall, cop_op); end
    next_cyc(); irq[2] = 1; mid();
    next_cyc(); mid();
    next_cyc(); mid();
    tests++; if (irq_pend !== 6'b000000) begin fails++; $display("FAIL irq2_pend_early: got %b want 000000", irq_pend); end
    next_cyc(); mid();
    tests++; if ({irq_pend, stall} !== {6'b000100, 1'b1}) begin fails++; $display("FAIL irq2_pend_set: got pend=%b stall=%0b want 000100/1", irq_pend, stall); end
    next_cyc(); irq[2] = 0; cop_out = 32'hDEAD_BEEF; mid();
    tests++; if (cop_op !== COP_OP_INT) begin fails++; $display("FAIL irq2_op: got %0d want %0d", cop_op, COP_OP_INT); end
    next_cyc(); cop_out = '0; mid();
    tests++; if (irq_pend !== 6'b000000) begin fails++; $display("FAIL irq2_pend_clr: got %b want 000000", irq_pend); end
    next_cyc(); mid();
    tests++; if ({redir_valid, redir_pc} !== {1'b1, INT_VEC}) begin fails++; $display("FAIL irq2_redir: got rv=%0b pc=%h want 1/%h", redir_valid, redir_pc, INT_VEC); end
  endtask

  task automatic test_irq_priority();
    run_op(COP_OP_RET, 32'h200, 32'h204);
    run_op(COP_OP_EN, 32'h300, 32'h0);
    next_cyc(); irq = 6'b001010; mid();
    next_cyc(); mid();
    next_cyc(); mid();
    next_cyc(); mid();
    tests++; if ({irq_pend, stall} !== {6'b001010, 1'b1}) begin fails++; $display("FAIL prio_pend: got pend=%b stall=%0b want 001010/1", irq_pend, stall); end
    next_cyc(); mid();
    tests++; if (cop_op !== COP_OP_INT) begin fails++; $display("FAIL prio_op1: got %0d want %0d", cop_op, COP_OP_INT); end
    next_cyc(); mid();
    tests++; if (irq_pend !== 6'b001000) begin fails++; $display("FAIL prio_line1_clr: got %b want 001000", irq_pend); end
    next_cyc(); mid();
    repeat (4) begin next_cyc(); mid(); end
    tests++; if ({stall, irq_pend} !== {1'b0, 6'b001000}) begin fails++; $display("FAIL prio_line3_wait: got stall=%0b pend=%b want 0/001000", stall, irq_pend); end
    run_op(COP_OP_RET, 32'h400, 32'h404);
    repeat (3) begin next_cyc(); mid(); end
    tests++; if ({stall, in_handler, irq_pend} !== {1'b0, 1'b0, 6'b001000}) begin fails++; $display("FAIL prio_ie_cleared: got stall=%0b inh=%0b pend=%b want 0/0/001000", stall, in_handler, irq_pend); end
    run_op(COP_OP_EN, 32'h500, 32'h0);
    next_cyc(); mid();
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL prio_line3_accept: got stall=%0b want 1", stall); end
    next_cyc(); mid();
    tests++; if (cop_op !== COP_OP_INT) begin fails++; $display("FAIL prio_op3: got %0d want %0d", cop_op, COP_OP_INT); end
    next_cyc(); mid();
    tests++; if (irq_pend !== 6'b000000) begin fails++; $display("FAIL prio_line3_clr: got %b want 000000", irq_pend); end
    next_cyc(); irq = '0; mid();
  endtask

  task automatic test_multi_flag();
    int stall_cnt = 0;
    int redir_cnt = 0;
    next_cyc(); ex_valid = 1; ex_break = 1; ex_syscall = 1; ex_code = 20'h7; ex_pc_next = 32'h600; mid();
    stall_cnt += int'(stall);
    next_cyc(); cop_out = 32'h3100; mid();
    tests++; if (cop_op !== COP_OP_BRK) begin fails++; $display("FAIL multi_op: got %0d want %0d", cop_op, COP_OP_BRK); end
    stall_cnt += int'(stall);
    next_cyc(); cop_out = '0; mid();
    stall_cnt += int'(stall);
    next_cyc(); clear_ex(); mid();
    tests++; if ({stall, redir_valid, redir_pc} !== {1'b0, 1'b1, 32'h3100}) begin fails++; $display("FAIL multi_redir: got stall=%0b rv=%0b pc=%h want 0/1/00003100", stall, redir_valid, redir_pc); end
    redir_cnt += int'(redir_valid);
    repeat (3) begin next_cyc(); mid(); stall_cnt += int'(stall); redir_cnt += int'(redir_valid); end
    tests++; if (stall_cnt != 3) begin fails++; $display("FAIL multi_stall_cycles: got %0d want 3", stall_cnt); end
    tests++; if (redir_cnt != 1) begin fails++; $display("FAIL multi_redir_count: got %0d want 1", redir_cnt); end
  endtask

  task automatic test_reset_midop();
    int rv_cnt = 0;
    next_cyc(); ex_valid = 1; ex_syscall = 1; ex_pc_next = 32'h700; mid();
    next_cyc(); clear_ex(); cop_out = 32'h3200; mid();
    next_cyc(); cop_out = '0; rst_n = 0; #1;
    tests++; if ({cop_op, stall, flush, redir_valid, redir_pc, in_handler} !== '0) begin fails++; $display("FAIL rst_async: got op=%0d stall=%0b rv=%0b pc=%h inh=%0b want all 0", cop_op, stall, redir_valid, redir_pc, in_handler); end
    mid(); rv_cnt += int'(redir_valid);
    next_cyc(); mid(); rv_cnt += int'(redir_valid);
    tests++; if ({cop_op, cop_next_pc, stall, flush, redir_pc, in_handler} !== '0) begin fails++; $display("FAIL rst_held: got op=%0d pc=%h stall=%0b flush=%0b want all 0", cop_op, cop_next_pc, stall, flush); end
    next_cyc(); rst_n = 1; mid(); rv_cnt += int'(redir_valid);
    repeat (3) begin next_cyc(); mid(); rv_cnt += int'(redir_valid | flush); end
    tests++; if (rv_cnt != 0) begin fails++; $display("FAIL rst_no_redirect: got %0d strobes want 0", rv_cnt); end
    next_cyc(); ex_valid = 1; ex_syscall = 1; ex_pc_next = 32'h800; mid();
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL rst_sys_accept: got stall=%0b want 1", stall); end
    next_cyc(); clear_ex(); cop_out = 32'h5000; mid();
    next_cyc(); cop_out = '0; mid();
    next_cyc(); mid();
    tests++; if ({redir_valid, redir_pc} !== {1'b1, 32'h5000}) begin fails++; $display("FAIL rst_sys_redir: got rv=%0b pc=%h want 1/00005000", redir_valid, redir_pc); end
  endtask

  initial begin
    test_reset();
    test_syscall();
    test_eret();
    test_irq_single();
    test_irq_priority();
    test_multi_flag();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
